// File: rtl/rt_dispatch_pkg.sv
// Shared widths, channel/counter types and the round-robin pick helper for
// the multi-core ray dispatcher.
package rt_dispatch_pkg;

  localparam int unsigned RAY_WIDTH     = 192;
  localparam int unsigned RESULT_WIDTH  = 97;

  localparam int unsigned DEF_NUM_CH    = 4;
  localparam int unsigned DEF_ORD_DEPTH = 32;
  localparam int unsigned DEF_MAX_OUT   = 8;
  localparam int unsigned DEF_CH_W      = (DEF_NUM_CH > 1) ? $clog2(DEF_NUM_CH) : 1;
  localparam int unsigned DEF_OUT_W     = $clog2(DEF_MAX_OUT + 1);

  // Widest channel bank the pick helper can scan.
  localparam int unsigned MAX_CH        = 32;
  localparam int unsigned MAX_CH_W      = 5;

  typedef logic [DEF_CH_W-1:0]  ch_idx_t;
  typedef logic [DEF_OUT_W-1:0] out_cnt_t;

  // First eligible channel scanning upward from rr, wrapping at n.
  function automatic int unsigned rr_pick(input logic [MAX_CH-1:0] eligible,
                                          input int unsigned       rr,
                                          input int unsigned       n);
    int unsigned idx;
    logic        found;
    rr_pick = rr;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = rr + k;
      if (idx >= n) idx = idx - n;
      if (!found && (k < n) && eligible[idx[MAX_CH_W-1:0]]) begin
        found   = 1'b1;
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/rt_order_fifo.sv
// Synchronous FIFO recording the channel index of every in-flight ray in
// issue order; pointers carry an extra wrap bit so occupancy is a subtraction.
module rt_order_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_head_c,
  output logic                     o_full_n_c,
  output logic                     o_empty_n_c,
  output logic [$clog2(DEPTH):0]   o_count_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_push;
  logic          w_pop;

  assign o_count_c   = r_wptr - r_rptr;
  assign o_full_n_c  = (o_count_c != (AW+1)'(DEPTH));
  assign o_empty_n_c = (r_wptr != r_rptr);
  assign o_head_c    = r_mem[r_rptr[AW-1:0]];
  assign w_push      = i_push && o_full_n_c;
  assign w_pop       = i_pop && o_empty_n_c;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/rt_multi_core_dispatch.sv
// Fans one ray stream out to NUM_CH rtcore channels round-robin and merges
// their results back into one stream in ray issue order.
module rt_multi_core_dispatch
  import rt_dispatch_pkg::*;
#(
  parameter int unsigned NUM_CH    = DEF_NUM_CH,
  parameter int unsigned ORD_DEPTH = DEF_ORD_DEPTH,
  parameter int unsigned MAX_OUT   = DEF_MAX_OUT
) (
  input  logic                             clk,
  input  logic                             arst,
  output logic                             ray_stream_full_n,
  input  logic                             ray_stream_write,
  input  logic [RAY_WIDTH-1:0]             ray_stream_din,
  output logic                             result_stream_empty_n,
  input  logic                             result_stream_read,
  output logic [RESULT_WIDTH-1:0]          result_stream_dout,
  input  logic [NUM_CH-1:0]                ch_ray_full_n,
  output logic [NUM_CH-1:0]                ch_ray_write,
  output logic [RAY_WIDTH-1:0]             ch_ray_din,
  input  logic [NUM_CH-1:0]                ch_result_empty_n,
  output logic [NUM_CH-1:0]                ch_result_read,
  input  logic [NUM_CH*RESULT_WIDTH-1:0]   ch_result_dout,
  output logic [$clog2(ORD_DEPTH):0]       inflight,
  output logic [31:0]                      issued_cnt,
  output logic [31:0]                      retired_cnt
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  logic [CH_W-1:0]   r_rr;
  logic [OUT_W-1:0]  r_out_cnt [NUM_CH];
  logic [31:0]       r_issued;
  logic [31:0]       r_retired;

  logic [MAX_CH-1:0] w_elig;
  logic [CH_W-1:0]   w_cand;
  logic [CH_W-1:0]   w_head;
  logic              w_fifo_full_n;
  logic              w_fifo_empty_n;
  logic              w_push;
  logic              w_pop;

  // Eligibility and dispatch/retire handshakes.
  always_comb begin
    w_elig = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_elig[c] = ch_ray_full_n[c] && (r_out_cnt[c] < OUT_W'(MAX_OUT));
    end
    w_cand = CH_W'(rr_pick(w_elig, 32'(r_rr), NUM_CH));

    // Masked by arst so the FIFO/counter reset state cannot advertise space.
    ray_stream_full_n     = !arst && (|w_elig) && w_fifo_full_n;
    w_push                = ray_stream_write && ray_stream_full_n;
    ch_ray_write          = w_push ? (NUM_CH'(1) << w_cand) : '0;
    ch_ray_din            = ray_stream_din;

    result_stream_empty_n = w_fifo_empty_n && ch_result_empty_n[w_head];
    result_stream_dout    = ch_result_dout[w_head*RESULT_WIDTH +: RESULT_WIDTH];
    w_pop                 = result_stream_read && result_stream_empty_n;
    ch_result_read        = w_pop ? (NUM_CH'(1) << w_head) : '0;
  end

  rt_order_fifo #(
    .W     (CH_W),
    .DEPTH (ORD_DEPTH)
  ) u_order (
    .clk         (clk),
    .arst        (arst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_din       (w_cand),
    .o_head_c    (w_head),
    .o_full_n_c  (w_fifo_full_n),
    .o_empty_n_c (w_fifo_empty_n),
    .o_count_c   (inflight)
  );

  // Per-channel outstanding counts, round-robin pointer and totals.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) r_out_cnt[c] <= '0;
      r_rr      <= '0;
      r_issued  <= '0;
      r_retired <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_ray_write[c] && !ch_result_read[c])
          r_out_cnt[c] <= r_out_cnt[c] + 1'b1;
        else if (!ch_ray_write[c] && ch_result_read[c])
          r_out_cnt[c] <= r_out_cnt[c] - 1'b1;
      end
      if (w_push) begin
        r_rr     <= (w_cand == CH_W'(NUM_CH - 1)) ? '0 : w_cand + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      if (w_pop) r_retired <= r_retired + 1'b1;
    end
  end

  assign issued_cnt  = r_issued;
  assign retired_cnt = r_retired;

endmodule

// File: tb/tb_rt_multi_core_dispatch.sv
// Directed and randomised checks of the dispatcher: a default instance driven
// through latency channel models, plus a shallow instance for limit corners.
module tb_rt_multi_core_dispatch;
  import rt_dispatch_pkg::*;

  localparam int unsigned RW = RAY_WIDTH;
  localparam int unsigned SW = RESULT_WIDTH;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default configuration
  logic            a_full_n, a_ray_write, a_empty_n, a_res_read;
  logic [RW-1:0]   a_ray_din, a_ch_ray_din;
  logic [SW-1:0]   a_dout;
  logic [3:0]      a_ch_ray_full_n, a_ch_ray_write, a_ch_res_empty_n, a_ch_res_read;
  logic [4*SW-1:0] a_ch_res_dout;
  logic [5:0]      a_inflight;
  logic [31:0]     a_issued, a_retired;

  // Instance B: ORD_DEPTH=4, MAX_OUT=2
  logic            b_full_n, b_ray_write, b_empty_n, b_res_read;
  logic [RW-1:0]   b_ray_din, b_ch_ray_din;
  logic [SW-1:0]   b_dout;
  logic [3:0]      b_ch_ray_full_n, b_ch_ray_write, b_ch_res_empty_n, b_ch_res_read;
  logic [4*SW-1:0] b_ch_res_dout;
  logic [2:0]      b_inflight;
  logic [31:0]     b_issued, b_retired;

  rt_multi_core_dispatch u_a (
    .clk(clk), .arst(arst),
    .ray_stream_full_n(a_full_n), .ray_stream_write(a_ray_write), .ray_stream_din(a_ray_din),
    .result_stream_empty_n(a_empty_n), .result_stream_read(a_res_read), .result_stream_dout(a_dout),
    .ch_ray_full_n(a_ch_ray_full_n), .ch_ray_write(a_ch_ray_write), .ch_ray_din(a_ch_ray_din),
    .ch_result_empty_n(a_ch_res_empty_n), .ch_result_read(a_ch_res_read), .ch_result_dout(a_ch_res_dout),
    .inflight(a_inflight), .issued_cnt(a_issued), .retired_cnt(a_retired)
  );

  rt_multi_core_dispatch #(.NUM_CH(4), .ORD_DEPTH(4), .MAX_OUT(2)) u_b (
    .clk(clk), .arst(arst),
    .ray_stream_full_n(b_full_n), .ray_stream_write(b_ray_write), .ray_stream_din(b_ray_din),
    .result_stream_empty_n(b_empty_n), .result_stream_read(b_res_read), .result_stream_dout(b_dout),
    .ch_ray_full_n(b_ch_ray_full_n), .ch_ray_write(b_ch_ray_write), .ch_ray_din(b_ch_ray_din),
    .ch_result_empty_n(b_ch_res_empty_n), .ch_result_read(b_ch_res_read), .ch_result_dout(b_ch_res_dout),
    .inflight(b_inflight), .issued_cnt(b_issued), .retired_cnt(b_retired)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Channel models for instance A: ring of {id, ready cycle} per channel.
  int unsigned m_id  [4][64];
  int          m_rdy [4][64];
  int          m_wr  [4];
  int          m_rd  [4];
  int          lat   [4];
  int unsigned exp_q [$];
  int          iss_cyc [256];
  int          ret_cyc [256];
  int          peak;
  int          acc_total;

  logic        nx_write, nx_read;
  logic [3:0]  nx_mask;
  int unsigned nx_id;

  function automatic logic [RW-1:0] mk_ray(input int unsigned id);
    return {id ^ 32'hDEAD_BEEF, 128'h0, id};
  endfunction

  function automatic logic [SW-1:0] mk_res(input int unsigned id);
    return {~id, id * 32'd3 + 32'd7, id, ^id};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record the transfers that the coming posedge will perform.
  task automatic book();
    logic        got_ret;
    int unsigned e;
    int unsigned p;
    got_ret = 1'b0;
    e       = 32'hFFFF_FFFF;
    if (32'(a_inflight) > peak) peak = 32'(a_inflight);
    for (int c = 0; c < 4; c++) begin
      if (a_ch_ray_write[c]) begin
        m_id[c][m_wr[c] % 64]  = a_ch_ray_din[31:0];
        m_rdy[c][m_wr[c] % 64] = cyc + 1 + lat[c];
        m_wr[c]++;
      end
    end
    if (a_ray_write && a_full_n) begin
      exp_q.push_back(a_ray_din[31:0]);
      if (a_ray_din[31:0] < 256) iss_cyc[a_ray_din[31:0]] = cyc + 1;
      acc_total++;
    end
    if (a_res_read && a_empty_n) begin
      got_ret = 1'b1;
      if (exp_q.size() == 0) begin
        chk("retire_without_issue", 128'(a_empty_n), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("retire_dout", 128'(a_dout), 128'(mk_res(e)));
        if (e < 256) ret_cyc[e] = cyc + 1;
      end
      chk("retire_ch_read", 128'(a_ch_res_read != 4'd0), 128'(1));
    end
    for (int c = 0; c < 4; c++) begin
      if (a_ch_res_read[c]) begin
        if (m_wr[c] == m_rd[c] || cyc < m_rdy[c][m_rd[c] % 64]) begin
          chk("ch_read_not_valid", 128'(c), 128'(32'hFFFF));
        end else begin
          p = m_id[c][m_rd[c] % 64];
          m_rd[c]++;
          chk("ch_read_src", 128'(p), got_ret ? 128'(e) : 128'(32'hFFFF_FFFF));
        end
      end
    end
  endtask

  // Advance one clock: refresh channel outputs, apply next inputs, then book.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    for (int c = 0; c < 4; c++) begin
      if (m_wr[c] != m_rd[c] && cyc >= m_rdy[c][m_rd[c] % 64]) begin
        a_ch_res_empty_n[c]          = 1'b1;
        a_ch_res_dout[c*SW +: SW]    = mk_res(m_id[c][m_rd[c] % 64]);
      end else begin
        a_ch_res_empty_n[c]          = 1'b0;
        a_ch_res_dout[c*SW +: SW]    = '0;
      end
    end
    a_ray_write     = nx_write;
    a_ray_din       = mk_ray(nx_id);
    a_res_read      = nx_read;
    a_ch_ray_full_n = nx_mask;
    @(negedge clk);
    book();
  endtask

  task automatic drain(input string name, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) chk(name, 128'(exp_q.size()), 128'(0));
  endtask

  typedef struct {
    int unsigned id;
    logic [3:0]  mask;
    logic        full;
    logic [3:0]  chw;
  } avec_t;

  typedef struct {
    logic [3:0]  mask;
    logic        wr;
    logic        rd;
    logic [3:0]  vld;
    logic        full;
    logic [3:0]  chw;
    logic        emp;
    logic [3:0]  chr;
    int unsigned infl;
    int unsigned head;
  } bvec_t;

  avec_t ta [13];
  bvec_t tb [12];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish, want finish by 3ms");
    $fatal(1);
  end

  initial begin
    ta[0]  = '{0,   4'hF, 1'b1, 4'b0001};
    ta[1]  = '{1,   4'hF, 1'b1, 4'b0010};
    ta[2]  = '{2,   4'hF, 1'b1, 4'b0100};
    ta[3]  = '{3,   4'hF, 1'b1, 4'b1000};
    ta[4]  = '{4,   4'hF, 1'b1, 4'b0001};
    ta[5]  = '{5,   4'hF, 1'b1, 4'b0010};
    ta[6]  = '{6,   4'hF, 1'b1, 4'b0100};
    ta[7]  = '{7,   4'hF, 1'b1, 4'b1000};
    ta[8]  = '{100, 4'h0, 1'b0, 4'b0000};
    ta[9]  = '{8,   4'hA, 1'b1, 4'b0010};
    ta[10] = '{9,   4'hA, 1'b1, 4'b1000};
    ta[11] = '{10,  4'hA, 1'b1, 4'b0010};
    ta[12] = '{11,  4'hA, 1'b1, 4'b1000};

    //          mask   wr    rd    vld    full  chw      emp   chr     infl head
    tb[0]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 4'b0010, 1'b0, 4'b0000, 0, 0};
    tb[1]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b0, 4'b0000, 1, 0};
    tb[2]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 4'b0010, 1'b0, 4'b0000, 2, 0};
    tb[3]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 4'b1000, 1'b0, 4'b0000, 3, 0};
    tb[4]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 4'b0000, 4, 0};
    tb[5]  = '{4'hA, 1'b0, 1'b1, 4'h2, 1'b0, 4'b0000, 1'b1, 4'b0010, 4, 1};
    tb[6]  = '{4'h8, 1'b1, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 4'b0000, 3, 0};
    tb[7]  = '{4'h2, 1'b1, 1'b0, 4'h0, 1'b1, 4'b0010, 1'b0, 4'b0000, 3, 0};
    tb[8]  = '{4'hA, 1'b0, 1'b0, 4'hA, 1'b0, 4'b0000, 1'b1, 4'b0000, 4, 3};
    tb[9]  = '{4'h5, 1'b1, 1'b1, 4'hA, 1'b0, 4'b0000, 1'b1, 4'b1000, 4, 3};
    tb[10] = '{4'h5, 1'b1, 1'b1, 4'hA, 1'b1, 4'b0100, 1'b1, 4'b0010, 3, 1};
    tb[11] = '{4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 4'b0000, 3, 0};

    for (int c = 0; c < 4; c++) begin
      m_wr[c] = 0; m_rd[c] = 0; lat[c] = 3;
      b_ch_res_dout[c*SW +: SW] = mk_res(50 + c);
    end
    peak = 0; acc_total = 0;
    nx_write = 1'b0; nx_read = 1'b0; nx_mask = 4'h0; nx_id = 0;

    // Reset with every request input active: outputs must stay quiet.
    a_ray_write = 1'b1; a_ray_din = mk_ray(999); a_res_read = 1'b1;
    a_ch_ray_full_n = 4'hF; a_ch_res_empty_n = 4'hF; a_ch_res_dout = '0;
    b_ray_write = 1'b1; b_ray_din = mk_ray(999); b_res_read = 1'b1;
    b_ch_ray_full_n = 4'hF; b_ch_res_empty_n = 4'hF;
    #1 arst = 1'b1;
    #2;
    chk("rst_a_full_n",   128'(a_full_n),       128'(0));
    chk("rst_a_empty_n",  128'(a_empty_n),      128'(0));
    chk("rst_a_ch_write", 128'(a_ch_ray_write), 128'(0));
    chk("rst_a_ch_read",  128'(a_ch_res_read),  128'(0));
    chk("rst_a_inflight", 128'(a_inflight),     128'(0));
    chk("rst_a_issued",   128'(a_issued),       128'(0));
    chk("rst_a_retired",  128'(a_retired),      128'(0));
    chk("rst_b_full_n",   128'(b_full_n),       128'(0));
    chk("rst_b_ch_write", 128'(b_ch_ray_write), 128'(0));
    chk("rst_b_ch_read",  128'(b_ch_res_read),  128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    a_ray_write = 1'b0; a_res_read = 1'b0; a_ch_ray_full_n = 4'h0; a_ch_res_empty_n = 4'h0;
    b_ray_write = 1'b0; b_res_read = 1'b0; b_ch_ray_full_n = 4'h0; b_ch_res_empty_n = 4'h0;
    arst = 1'b0;

    // Round-robin order, masked channels and a blocked cycle, 3-cycle channels.
    nx_read = 1'b1;
    for (int i = 0; i < 13; i++) begin
      nx_write = 1'b1; nx_id = ta[i].id; nx_mask = ta[i].mask;
      step();
      chk($sformatf("t1_full_n[%0d]", i),   128'(a_full_n),       128'(ta[i].full));
      chk($sformatf("t1_ch_write[%0d]", i), 128'(a_ch_ray_write), 128'(ta[i].chw));
    end
    nx_write = 1'b0; nx_mask = 4'hF;
    drain("t1_drain", 100);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t1_back_to_back[%0d]", i), 128'(ret_cyc[i+1] - ret_cyc[i]), 128'(1));
    step();
    chk("t1_issued",  128'(a_issued),  128'(12));
    chk("t1_retired", 128'(a_retired), 128'(12));

    // Slow channel 0 holds back faster channels until its ray retires.
    lat[0] = 20; lat[1] = 2; lat[2] = 2; lat[3] = 2;
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      nx_write = 1'b1; nx_id = 200 + i;
      step();
      chk($sformatf("t2_ch_write[%0d]", i), 128'(a_ch_ray_write), 128'(4'b0001 << i));
    end
    nx_write = 1'b0;
    drain("t2_drain", 80);
    chk("t2_ray0_latency", 128'((ret_cyc[200] - iss_cyc[200]) >= 20 && (ret_cyc[200] - iss_cyc[200]) <= 22), 128'(1));
    chk("t2_follow1", 128'(ret_cyc[201] - ret_cyc[200]), 128'(1));
    chk("t2_follow2", 128'(ret_cyc[202] - ret_cyc[201]), 128'(1));
    chk("t2_follow3", 128'(ret_cyc[203] - ret_cyc[202]), 128'(1));
    chk("t2_peak_inflight", 128'(peak), 128'(4));
    step();
    chk("t2_issued", 128'(a_issued), 128'(16));

    // Random ready masks and consumer stalls over 5000 rays.
    lat[0] = 3; lat[1] = 5; lat[2] = 1; lat[3] = 7;
    begin
      int base;
      base = acc_total;
      for (int k = 0; k < 60000 && (acc_total - base) < 5000; k++) begin
        nx_write = ($urandom_range(3) != 0);
        nx_id    = 1000 + (acc_total - base);
        nx_read  = ($urandom_range(3) != 0);
        nx_mask  = 4'($urandom_range(15));
        step();
      end
      chk("t5_accepted", 128'(acc_total - base), 128'(5000));
    end
    nx_write = 1'b0; nx_read = 1'b1; nx_mask = 4'hF;
    drain("t5_drain", 500);
    step();
    chk("t5_issued",   128'(a_issued),   128'(5016));
    chk("t5_retired",  128'(a_retired),  128'(5016));
    chk("t5_inflight", 128'(a_inflight), 128'(0));

    // Reset with rays in flight and results waiting, then a fresh ray.
    lat[0] = 2; lat[1] = 2; lat[2] = 2; lat[3] = 2;
    nx_read = 1'b0;
    for (int i = 0; i < 5; i++) begin
      nx_write = 1'b1; nx_id = 300 + i;
      step();
    end
    nx_write = 1'b0;
    repeat (4) step();
    chk("t6_pre_empty_n",  128'(a_empty_n),  128'(1));
    chk("t6_pre_inflight", 128'(a_inflight), 128'(5));
    a_ray_write = 1'b1; a_res_read = 1'b1;
    #2 arst = 1'b1;
    #1;
    chk("t6_full_n",   128'(a_full_n),       128'(0));
    chk("t6_empty_n",  128'(a_empty_n),      128'(0));
    chk("t6_ch_write", 128'(a_ch_ray_write), 128'(0));
    chk("t6_ch_read",  128'(a_ch_res_read),  128'(0));
    chk("t6_inflight", 128'(a_inflight),     128'(0));
    chk("t6_issued",   128'(a_issued),       128'(0));
    chk("t6_retired",  128'(a_retired),      128'(0));
    for (int c = 0; c < 4; c++) begin m_wr[c] = 0; m_rd[c] = 0; end
    exp_q.delete();
    nx_write = 1'b0; nx_read = 1'b1;
    step();
    arst = 1'b0;
    nx_write = 1'b1; nx_id = 400;
    step();
    chk("t6_post_ch_write", 128'(a_ch_ray_write), 128'(4'b0001));
    nx_write = 1'b0;
    drain("t6_drain", 40);
    step();
    chk("t6_post_issued",  128'(a_issued),  128'(1));
    chk("t6_post_retired", 128'(a_retired), 128'(1));

    // Shallow instance: per-channel limit, full FIFO, push and pop together.
    nx_read = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b_ch_ray_full_n  = tb[i].mask;
      b_ray_write      = tb[i].wr;
      b_ray_din        = mk_ray(500 + i);
      b_res_read       = tb[i].rd;
      b_ch_res_empty_n = tb[i].vld;
      #1;
      chk($sformatf("b_full_n[%0d]", i),   128'(b_full_n),       128'(tb[i].full));
      chk($sformatf("b_ch_write[%0d]", i), 128'(b_ch_ray_write), 128'(tb[i].chw));
      chk($sformatf("b_empty_n[%0d]", i),  128'(b_empty_n),      128'(tb[i].emp));
      chk($sformatf("b_ch_read[%0d]", i),  128'(b_ch_res_read),  128'(tb[i].chr));
      chk($sformatf("b_inflight[%0d]", i), 128'(b_inflight),     128'(tb[i].infl));
      if (tb[i].emp)
        chk($sformatf("b_dout[%0d]", i), 128'(b_dout), 128'(mk_res(50 + tb[i].head)));
      if (tb[i].wr)
        chk($sformatf("b_ch_din[%0d]", i), 128'(b_ch_ray_din[31:0]), 128'(500 + i));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
